// File: rtl/prog_delay_line.sv
// RAM-backed delay line with a run-time programmable length (1..MAX_DEPTH).
// A fill count masks stale RAM words, so the RAM itself never needs clearing.
module prog_delay_line #(
   parameter int WIDTH         = 16,
   parameter int MAX_DEPTH     = 512,
   parameter int DEFAULT_DELAY = 512,
   localparam int ADDR         = $clog2(MAX_DEPTH),
   localparam int LW           = ADDR + 1
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             CLK_en,
   input  logic             load_len,
   input  logic [LW-1:0]    delay_len,
   input  logic [WIDTH-1:0] shiftin,
   output logic [WIDTH-1:0] shiftout,
   output logic             out_valid,
   output logic [LW-1:0]    fill_level
);

   localparam logic [LW-1:0] MAX_LW = LW'(MAX_DEPTH);
   localparam logic [LW-1:0] DEF_LW = LW'(DEFAULT_DELAY);

   logic [WIDTH-1:0] mem [MAX_DEPTH];

   logic [ADDR-1:0]  wrAddr_q, wrAddr_d;
   logic [LW-1:0]    fill_q, fill_d;
   logic [LW-1:0]    dly_q, dly_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic [LW-1:0]    lenClamp;
   logic [ADDR-1:0]  rdAddr;

   // D == MAX_DEPTH truncates to 0 here, so read and write addresses coincide.
   assign rdAddr = wrAddr_q - dly_q[ADDR-1:0];

   always_comb begin
      if (delay_len == '0)
         lenClamp = LW'(1);
      else if (delay_len > MAX_LW)
         lenClamp = MAX_LW;
      else
         lenClamp = delay_len;
   end

   always_comb begin
      wrAddr_d = wrAddr_q;
      fill_d   = fill_q;
      dly_d    = dly_q;
      out_d    = out_q;
      valid_d  = valid_q;
      if (load_len) begin
         dly_d   = lenClamp;
         fill_d  = CLK_en ? LW'(1) : '0;
         out_d   = '0;
         valid_d = 1'b0;
         if (CLK_en)
            wrAddr_d = wrAddr_q + 1'b1;
      end else if (CLK_en) begin
         wrAddr_d = wrAddr_q + 1'b1;
         if (fill_q >= dly_q) begin
            out_d   = mem[rdAddr];
            valid_d = 1'b1;
         end else begin
            out_d   = '0;
            valid_d = 1'b0;
         end
         if (fill_q != MAX_LW)
            fill_d = fill_q + 1'b1;
      end
   end

   // The RAM is never reset; the non-blocking write gives read-first behaviour.
   always_ff @(posedge CLK) begin
      if (CLK_en && !reset)
         mem[wrAddr_q] <= shiftin;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wrAddr_q <= '0;
         fill_q   <= '0;
         dly_q    <= DEF_LW;
         out_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         wrAddr_q <= wrAddr_d;
         fill_q   <= fill_d;
         dly_q    <= dly_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
      end
   end

   assign shiftout   = out_q;
   assign out_valid  = valid_q;
   assign fill_level = fill_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line (WIDTH=16, MAX_DEPTH=8, DEFAULT_DELAY=8).
// The reference keeps a queue of samples written since reset/reload and indexes it by delay.
module tb_prog_delay_line;

   localparam int WIDTH = 16;
   localparam int MAXD  = 8;
   localparam int LW    = 4;

   logic             CLK;
   logic             reset;
   logic             CLK_en;
   logic             load_len;
   logic [LW-1:0]    delay_len;
   logic [WIDTH-1:0] shiftin;
   logic [WIDTH-1:0] shiftout;
   logic             out_valid;
   logic [LW-1:0]    fill_level;

   int checks = 0;
   int failures = 0;

   int               mdlD;
   logic [WIDTH-1:0] hist[$];
   logic [WIDTH-1:0] expOut;
   logic             expValid;
   int               expFill;

   prog_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .DEFAULT_DELAY(MAXD)) dut (
      .CLK(CLK), .reset(reset), .CLK_en(CLK_en), .load_len(load_len),
      .delay_len(delay_len), .shiftin(shiftin), .shiftout(shiftout),
      .out_valid(out_valid), .fill_level(fill_level)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one clock of stimulus, then advance the reference model with the same inputs.
   task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                input logic [LW-1:0] len, input logic [WIDTH-1:0] din);
      reset = rst; CLK_en = en; load_len = ld; delay_len = len; shiftin = din;
      @(posedge CLK);
      #1;
      if (rst) begin
         hist.delete(); mdlD = MAXD; expOut = '0; expValid = 1'b0;
      end else if (ld) begin
         mdlD = (len == 0) ? 1 : ((int'(len) > MAXD) ? MAXD : int'(len));
         hist.delete();
         if (en) hist.push_back(din);
         expOut = '0; expValid = 1'b0;
      end else if (en) begin
         if (hist.size() >= mdlD) begin
            expOut = hist[hist.size() - mdlD]; expValid = 1'b1;
         end else begin
            expOut = '0; expValid = 1'b0;
         end
         hist.push_back(din);
         if (hist.size() > MAXD) void'(hist.pop_front());
      end
      expFill = hist.size();
   endtask

   task automatic test_reset();
      applyStimulus(1, 0, 0, 0, 16'hAAAA);
      applyStimulus(1, 1, 1, 4'd3, 16'h5555);
      checks++;
      if ({shiftout, out_valid, fill_level} !== {16'h0, 1'b0, 4'd0}) begin
         failures++;
         $display("[TB] FAIL reset: got out=%h v=%b fill=%0d, expected 0/0/0", shiftout, out_valid, fill_level);
      end
      applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic test_ramp_d3();
      applyStimulus(0, 0, 1, 4'd3, 0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(0, 1, 0, 4'd0, WIDTH'(i));
         checks++;
         if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
            failures++;
            $display("[TB] FAIL ramp_d3 en%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                     i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
         end
         if (i == 4) begin
            checks++;
            if ({out_valid, shiftout} !== {1'b1, 16'd1}) begin
               failures++;
               $display("[TB] FAIL ramp_d3_first_valid: got v=%b out=%0d, expected v=1 out=1", out_valid, shiftout);
            end
         end
      end
   endtask

   task automatic test_max_delay();
      applyStimulus(0, 0, 1, 4'd8, 0);
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(0, 1, 0, 4'd0, WIDTH'(i));
         checks++;
         if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
            failures++;
            $display("[TB] FAIL max_delay en%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                     i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
         end
         if (i == 9) begin
            checks++;
            if ({out_valid, shiftout, fill_level} !== {1'b1, 16'd1, 4'd8}) begin
               failures++;
               $display("[TB] FAIL max_delay_first_valid: got v=%b out=%0d fill=%0d, expected v=1 out=1 fill=8",
                        out_valid, shiftout, fill_level);
            end
         end
      end
   endtask

   task automatic test_enable_gaps();
      int n = 0;
      applyStimulus(0, 0, 1, 4'd2, 0);
      for (int i = 0; i < 14; i++) begin
         logic en = (i % 2 == 0);
         if (en) n++;
         applyStimulus(0, en, 0, 4'd7, en ? WIDTH'(n) : 16'hDEAD);
         checks++;
         if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
            failures++;
            $display("[TB] FAIL enable_gaps cyc%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                     i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
         end
      end
   endtask

   task automatic test_reload_midstream();
      logic [WIDTH-1:0] loadSample;
      applyStimulus(0, 0, 1, 4'd3, 0);
      for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 0, 0, WIDTH'(16'h100 + i));
      loadSample = WIDTH'($urandom);
      applyStimulus(0, 1, 1, 4'd5, loadSample);
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(0, 1, 0, 4'd1, WIDTH'($urandom));
         checks++;
         if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
            failures++;
            $display("[TB] FAIL reload en%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                     i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
         end
         if (i == 5) begin
            checks++;
            if ({out_valid, shiftout} !== {1'b1, loadSample}) begin
               failures++;
               $display("[TB] FAIL reload_first_valid: got v=%b out=%h, expected v=1 out=%h", out_valid, shiftout, loadSample);
            end
         end
      end
   endtask

   task automatic test_clamp();
      logic [LW-1:0] lens [2] = '{4'd0, 4'd12};
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 0, 1, lens[k], 0);
         for (int i = 1; i <= 11; i++) begin
            applyStimulus(0, 1, 0, 4'd2, WIDTH'($urandom));
            checks++;
            if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
               failures++;
               $display("[TB] FAIL clamp len%0d en%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                        lens[k], i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      applyStimulus(0, 0, 1, 4'd2, 0);
      for (int i = 1; i <= 9; i++) applyStimulus(0, 1, 0, 0, WIDTH'(16'hF00 + i));
      applyStimulus(1, 1, 1, 4'd1, 16'hBEEF);
      checks++;
      if ({shiftout, out_valid, fill_level} !== {16'h0, 1'b0, 4'd0}) begin
         failures++;
         $display("[TB] FAIL reset_midrun: got out=%h v=%b fill=%0d, expected 0/0/0", shiftout, out_valid, fill_level);
      end
      // Default delay is MAX_DEPTH, so old RAM words at every address must stay masked.
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(0, 1, 0, 4'd1, WIDTH'(16'h200 + i));
         checks++;
         if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
            failures++;
            $display("[TB] FAIL reset_midrun en%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                     i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic rst = ($urandom_range(0, 59) == 0);
         logic ld  = ($urandom_range(0, 14) == 0);
         logic en  = ($urandom_range(0, 9) < 7);
         applyStimulus(rst, en, ld, LW'($urandom_range(0, 15)), WIDTH'($urandom));
         checks++;
         if ({shiftout, out_valid, fill_level} !== {expOut, expValid, LW'(expFill)}) begin
            failures++;
            $display("[TB] FAIL random cyc%0d: got out=%h v=%b fill=%0d, expected out=%h v=%b fill=%0d",
                     i, shiftout, out_valid, fill_level, expOut, expValid, expFill);
         end
      end
   endtask

   initial begin
      reset = 1'b1; CLK_en = 1'b0; load_len = 1'b0; delay_len = '0; shiftin = '0;
      mdlD = MAXD; expOut = '0; expValid = 1'b0; expFill = 0;
      test_reset();
      test_ramp_d3();
      test_max_delay();
      test_enable_gaps();
      test_reload_midstream();
      test_clamp();
      test_reset_midrun();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
